// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// a clog2 variant that never yields a zero-width vector.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

    function automatic int safe_clog2(input int value);
        int result;
        if (value > 1) begin
            result = $clog2(value);
        end else begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// Single-bit request synchronizer: a SYNC_LEN flop chain whose reset value is
// "request asserted", so the domain stays in reset until the chain flushes.
module reset_sync_bit
    import reset_seq_pkg::*;
#(
    parameter int SYNC_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (SYNC_LEN < 2) begin : g_bad_sync_len
        $error("reset_sync_bit: SYNC_LEN must be at least 2");
    end

    logic [SYNC_LEN-1:0] chain_q;
    logic [SYNC_LEN-1:0] chain_d;

    // Shift the normalised request one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[SYNC_LEN-2:0], d};
    end

    // Chain storage; reset forces every stage to the asserted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {SYNC_LEN{1'b1}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[SYNC_LEN-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: synchronizes NUM_IN async requests plus a
// software request, stretches the combined request, then releases outputs in order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                NUM_IN      = 2,
    parameter logic [NUM_IN-1:0] IN_POLARITY = {NUM_IN{1'b1}},
    parameter int                NUM_OUT     = 4,
    parameter int                SYNC_LEN    = 3,
    parameter int                STRETCH     = 16,
    parameter int                STEP        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IN-1:0]  rst_req_in,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               busy,
    output logic               done
);

    localparam int CNT_MAX = (STRETCH > STEP) ? STRETCH : STEP;
    localparam int CNT_W   = safe_clog2(CNT_MAX + 1);
    localparam int IDX_W   = safe_clog2(NUM_OUT);

    localparam logic [CNT_W-1:0]   STRETCH_C = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ALL_ON    = {NUM_OUT{1'b1}};
    localparam logic [NUM_OUT-1:0] BIT0      = NUM_OUT'(1);

    if (SYNC_LEN < 2) begin : g_bad_sync_len
        $error("reset_sequencer: SYNC_LEN must be at least 2");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $error("reset_sequencer: STRETCH must be at least 1");
    end
    if (STEP < 1) begin : g_bad_step
        $error("reset_sequencer: STEP must be at least 1");
    end
    if (NUM_OUT < 1) begin : g_bad_num_out
        $error("reset_sequencer: NUM_OUT must be at least 1");
    end

    // XNOR with the polarity mask maps every input onto active-high.
    logic [NUM_IN-1:0] req_norm;
    logic [NUM_IN-1:0] req_sync;
    logic              req;

    assign req_norm = ~(rst_req_in ^ IN_POLARITY);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
        reset_sync_bit #(
            .SYNC_LEN (SYNC_LEN)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_norm[i]),
            .q   (req_sync[i])
        );
    end

    assign req = (|req_sync) | sw_rst_req;

    seq_state_e         state_q,   state_d;
    logic [CNT_W-1:0]   stretch_q, stretch_d;
    logic [CNT_W-1:0]   step_q,    step_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Next-state, counter and output computation for the release sequence.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        step_d    = step_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;

        case (state_q)
            HOLD: begin
                rst_out_d = ALL_ON;
                if (req) begin
                    stretch_d = '0;
                end else if (stretch_q == STRETCH_C) begin
                    stretch_d = '0;
                    step_d    = '0;
                    idx_d     = '0;
                    rst_out_d = ~BIT0;
                    if (NUM_OUT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    stretch_d = stretch_q + CNT_ONE;
                end
            end
            RELEASE: begin
                if (req) begin
                    state_d   = HOLD;
                    stretch_d = '0;
                    step_d    = '0;
                    idx_d     = '0;
                    rst_out_d = ALL_ON;
                end else if (step_q == STEP_LAST) begin
                    step_d    = '0;
                    idx_d     = idx_q + IDX_ONE;
                    rst_out_d = rst_out_q & ~(BIT0 << idx_d);
                    if (idx_d == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    step_d = step_q + CNT_ONE;
                end
            end
            DONE: begin
                if (req) begin
                    state_d   = HOLD;
                    stretch_d = '0;
                    step_d    = '0;
                    idx_d     = '0;
                    rst_out_d = ALL_ON;
                end else begin
                    rst_out_d = '0;
                end
            end
            default: begin
                state_d   = HOLD;
                stretch_d = '0;
                step_d    = '0;
                idx_d     = '0;
                rst_out_d = ALL_ON;
            end
        endcase

        busy_d = |rst_out_d;
        done_d = ~(|rst_out_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD;
            stretch_q <= '0;
            step_q    <= '0;
            idx_q     <= '0;
            rst_out_q <= ALL_ON;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rst_out = rst_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a reference model counts quiet edges
// and derives each output bit from release thresholds; a monitor compares.
module tb_reset_sequencer;

    localparam int         SYNC_LEN = 3;
    localparam int         STRETCH  = 16;
    localparam int         STEP     = 8;
    localparam int         NUM_OUT  = 4;
    localparam logic [1:0] IN_POL   = 2'b01;  // bit0 active-high, bit1 active-low
    localparam logic [1:0] IN_IDLE  = 2'b10;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rst_req_in;
    logic         sw_rst_req;
    logic [3:0]   rst_out;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [3:0] rst_out;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    logic hist[$];
    int   quiet  = 0;
    int   checks = 0;
    int   errors = 0;

    reset_sequencer #(
        .NUM_IN      (2),
        .IN_POLARITY (IN_POL),
        .NUM_OUT     (NUM_OUT),
        .SYNC_LEN    (SYNC_LEN),
        .STRETCH     (STRETCH),
        .STEP        (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rst_req_in (rst_req_in),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference model: an output bit k is released once the run of edges with
    // no reset and no request reaches STRETCH+1+k*STEP.
    task automatic model_step();
        logic [1:0] pol;
        logic       norm;
        logic       synced;
        logic       req;
        obs_t       e;
        pol  = IN_POL;
        norm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (pol[i]) norm = norm | rst_req_in[i];
            else        norm = norm | !rst_req_in[i];
        end
        if (rst) norm = 1'b1;
        if (hist.size() < SYNC_LEN) synced = 1'b1;
        else                        synced = hist.pop_front();
        hist.push_back(norm);
        req = synced | sw_rst_req;
        if (rst || req)          quiet = 0;
        else if (quiet < 100000) quiet = quiet + 1;
        for (int k = 0; k < NUM_OUT; k++) begin
            e.rst_out[k] = (quiet < (STRETCH + 1 + k * STEP));
        end
        e.busy = |e.rst_out;
        e.done = (e.rst_out == 4'h0);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare every registered output against the scoreboard.
    initial begin
        obs_t       want;
        logic [3:0] viol;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want   = exp_q.pop_front();
                checks = checks + 1;
                if ({rst_out, busy, done} !== want) begin
                    errors = errors + 1;
                    $display("FAIL outputs @%0t: got rst_out=%h busy=%b done=%b, expected rst_out=%h busy=%b done=%b",
                             $time, rst_out, busy, done, want.rst_out, want.busy, want.done);
                end
                viol   = (rst_out << 1) & ~rst_out;
                checks = checks + 1;
                if (viol !== 4'h0) begin
                    errors = errors + 1;
                    $display("FAIL ordering @%0t: rst_out=%h, violating bits=%h, expected 0",
                             $time, rst_out, viol);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios followed by randomized events.
    initial begin
        int op;
        int len;
        rst        = 1'b1;
        sw_rst_req = 1'b0;
        rst_req_in = IN_IDLE;
        cycles(3);
        rst = 1'b0;
        cycles(60);

        rst_req_in[0] = 1'b1;
        cycles(5);
        rst_req_in[0] = 1'b0;
        cycles(60);

        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(30);
        sw_rst_req = 1'b1;
        cycles(1);
        sw_rst_req = 1'b0;
        cycles(60);

        rst_req_in[1] = 1'b0;
        cycles(40);
        rst_req_in[1] = 1'b1;
        cycles(60);

        for (int t = 0; t < 6; t++) begin
            rst_req_in[0] = ~rst_req_in[0];
            cycles(10);
        end
        rst_req_in[0] = 1'b0;
        cycles(25);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(60);

        for (int it = 0; it < 40; it++) begin
            op  = $urandom_range(0, 4);
            len = $urandom_range(1, 6);
            case (op)
                0: cycles($urandom_range(1, 60));
                1: begin rst_req_in[0] = 1'b1; cycles(len); rst_req_in[0] = 1'b0; end
                2: begin rst_req_in[1] = 1'b0; cycles(len); rst_req_in[1] = 1'b1; end
                3: begin sw_rst_req = 1'b1; cycles(1); sw_rst_req = 1'b0; end
                default: begin rst = 1'b1; cycles($urandom_range(1, 3)); rst = 1'b0; end
            endcase
            cycles($urandom_range(0, 25));
        end
        cycles(70);

        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
